// File: rtl/midi_synth_pkg.sv
// ============================================================================
// midi_synth_pkg : shared types, MIDI constants and the note -> half-period ROM
// Revision 1.0
// ============================================================================
`default_nettype none

package midi_synth_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_NOTE = 3'd1;
    localparam logic [2:0] ST_GET_VEL  = 3'd2;
    localparam logic [2:0] ST_SKIP1    = 3'd3;
    localparam logic [2:0] ST_SKIP2    = 3'd4;

    typedef struct packed {
        logic       active;
        logic [6:0] note;
        logic [6:0] vel;
    } voice_t;

    // round(1000*2^((48-n)/12)): top-octave values in 16.16 fixed point,
    // shifted down one bit per octave and rounded half-up.
    function automatic logic [15:0] HALF_PERIOD(input logic [6:0] n);
        logic [6:0]  oct;
        logic [6:0]  semi;
        logic [30:0] k;
        logic [30:0] sh;
        oct  = n / 7'd12;
        semi = n % 7'd12;
        case (semi)
            7'd0:    k = 31'd1048576000;
            7'd1:    k = 31'd989723951;
            7'd2:    k = 31'd934175014;
            7'd3:    k = 31'd881743799;
            7'd4:    k = 31'd832255323;
            7'd5:    k = 31'd785544421;
            7'd6:    k = 31'd741455200;
            7'd7:    k = 31'd699840517;
            7'd8:    k = 31'd660561488;
            7'd9:    k = 31'd623487020;
            7'd10:   k = 31'd588493383;
            default: k = 31'd555463787;
        endcase
        sh = (k + (31'd1 << (7'd15 + oct))) >> (7'd16 + oct);
        if (sh == 31'd0) begin
            return 16'd1;
        end
        return sh[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_synth_voice.sv
// ============================================================================
// midi_synth_voice : one square-wave oscillator with velocity amplitude
// Revision 1.0
// ============================================================================
`default_nettype none

module midi_synth_voice
    import midi_synth_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int AMP_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [6:0]              note,
    input  logic [6:0]              vel,
    output logic                    active,
    output logic signed [OUT_W-1:0] contrib
);

    voice_t             rec_q, rec_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [15:0]        half_period;
    logic signed [OUT_W-1:0] amp;

    assign half_period = HALF_PERIOD(rec_q.note);
    assign amp         = OUT_W'(rec_q.vel) << AMP_SHIFT;

    // A start outranks both a stop and a wrap landing in the same cycle.
    always_comb begin
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (start) begin
            rec_d.active = 1'b1;
            rec_d.note   = note;
            rec_d.vel    = vel;
            cnt_d        = 16'd0;
            phase_d      = 1'b0;
        end else begin
            if (rec_q.active) begin
                if (cnt_q == half_period - 16'd1) begin
                    cnt_d   = 16'd0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            if (stop) begin
                rec_d.active = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q   <= '0;
            cnt_q   <= 16'd0;
            phase_q <= 1'b0;
        end else begin
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign active  = rec_q.active;
    assign contrib = !rec_q.active ? '0 : (phase_q ? -amp : amp);

endmodule

`default_nettype wire

// File: rtl/midi_poly_synth.sv
// ============================================================================
// midi_poly_synth : MIDI parser, voice allocator and mixer for NUM_VOICES
// square-wave oscillators. Optional MIDI_POLY_SYNTH_CHANNEL_FILTER_EN limits
// Note On/Off to channel MIDI_CH (default build is omni).
// Revision 1.0
// ============================================================================
`default_nettype none

module midi_poly_synth
    import midi_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int OUT_W      = 16,
    parameter int AMP_SHIFT  = 6,
    parameter int SAMPLE_DIV = 512,
    parameter int MIDI_CH    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              midi_data,
    input  logic                    midi_valid,
    output logic signed [OUT_W-1:0] sound_data,
    output logic                    sound_valid,
    output logic [NUM_VOICES-1:0]   voice_active
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    generate
        if (NUM_VOICES < 1 || NUM_VOICES > 16 || SAMPLE_DIV < 1 ||
            MIDI_CH < 0 || MIDI_CH > 15 ||
            (longint'(NUM_VOICES * 127) << AMP_SHIFT) >
            ((longint'(1) << (OUT_W - 1)) - 1)) begin : g_param_check
            $error("midi_poly_synth: illegal parameter set");
        end
    endgenerate

    logic [2:0]  state_q, state_d;
    logic        rs_valid_q, rs_valid_d;
    logic        rs_on_q, rs_on_d;
    logic [6:0]  note_q, note_d;
    logic        ch_ok;
    logic        msg_done;
    logic        msg_on;

`ifdef MIDI_POLY_SYNTH_CHANNEL_FILTER_EN
    assign ch_ok = (midi_data[3:0] == 4'(MIDI_CH));
`else
    assign ch_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        note_d     = note_q;
        msg_done   = 1'b0;
        if (midi_valid) begin
            if (midi_data[7]) begin
                if (midi_data[7:3] == 5'b11111) begin
                    // realtime bytes pass through without disturbing anything
                end else if (midi_data[7:4] == 4'hF) begin
                    rs_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if ((midi_data[7:4] == NOTE_OFF || midi_data[7:4] == NOTE_ON) && ch_ok) begin
                    rs_valid_d = 1'b1;
                    rs_on_d    = midi_data[4];
                    state_d    = ST_GET_NOTE;
                end else begin
                    rs_valid_d = 1'b0;
                    state_d    = (midi_data[7:4] == 4'hC || midi_data[7:4] == 4'hD) ? ST_SKIP1 : ST_SKIP2;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rs_valid_q) begin
                            note_d  = midi_data[6:0];
                            state_d = ST_GET_VEL;
                        end
                    end
                    ST_GET_NOTE: begin
                        note_d  = midi_data[6:0];
                        state_d = ST_GET_VEL;
                    end
                    ST_GET_VEL: begin
                        msg_done = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    ST_SKIP2: state_d = ST_SKIP1;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign msg_on = rs_on_q && (midi_data[6:0] != 7'd0);

    logic [NUM_VOICES-1:0]   act;
    logic [NUM_VOICES-1:0]   start_v, stop_v;
    logic [6:0]              note_tab_q [NUM_VOICES];
    logic [6:0]              note_tab_d [NUM_VOICES];
    logic [VW-1:0]           steal_q, steal_d;
    logic                    hit, free;
    logic [VW-1:0]           hit_idx, free_idx;
    logic signed [OUT_W-1:0] contrib [NUM_VOICES];

    // Scanning downward leaves the lowest matching index in hit_idx/free_idx.
    always_comb begin
        start_v  = '0;
        stop_v   = '0;
        steal_d  = steal_q;
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (act[i] && note_tab_q[i] == note_q) begin
                hit     = 1'b1;
                hit_idx = VW'(i);
            end
            if (!act[i]) begin
                free     = 1'b1;
                free_idx = VW'(i);
            end
        end
        if (msg_done) begin
            if (msg_on) begin
                if (hit) begin
                    start_v[hit_idx] = 1'b1;
                end else if (free) begin
                    start_v[free_idx] = 1'b1;
                end else begin
                    start_v[steal_q] = 1'b1;
                    steal_d = (steal_q == VW'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
                end
            end else if (hit) begin
                stop_v[hit_idx] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_tab_d[i] = start_v[i] ? note_q : note_tab_q[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
            midi_synth_voice #(
                .OUT_W     (OUT_W),
                .AMP_SHIFT (AMP_SHIFT)
            ) u_voice (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start_v[g]),
                .stop    (stop_v[g]),
                .note    (note_q),
                .vel     (midi_data[6:0]),
                .active  (act[g]),
                .contrib (contrib[g])
            );
        end
    endgenerate

    logic signed [OUT_W-1:0] mix_q, mix_d;
    logic [DW-1:0]           div_q, div_d;
    logic                    div_wrap;
    logic signed [OUT_W-1:0] sound_data_q, sound_data_d;
    logic                    sound_valid_q, sound_valid_d;

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_d = mix_d + contrib[i];
        end
    end

    assign div_wrap      = (div_q == DW'(SAMPLE_DIV - 1));
    assign div_d         = div_wrap ? '0 : div_q + 1'b1;
    assign sound_data_d  = div_wrap ? mix_q : sound_data_q;
    assign sound_valid_d = div_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rs_valid_q    <= 1'b0;
            rs_on_q       <= 1'b0;
            note_q        <= 7'd0;
            steal_q       <= '0;
            note_tab_q    <= '{default: '0};
            mix_q         <= '0;
            div_q         <= '0;
            sound_data_q  <= '0;
            sound_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rs_valid_q    <= rs_valid_d;
            rs_on_q       <= rs_on_d;
            note_q        <= note_d;
            steal_q       <= steal_d;
            note_tab_q    <= note_tab_d;
            mix_q         <= mix_d;
            div_q         <= div_d;
            sound_data_q  <= sound_data_d;
            sound_valid_q <= sound_valid_d;
        end
    end

    assign sound_data   = sound_data_q;
    assign sound_valid  = sound_valid_q;
    assign voice_active = act;

endmodule

`default_nettype wire

// File: tb/tb_midi_poly_synth.sv
// Randomized + directed bench: a reference model predicts voice_active every
// cycle and each sample strobe; a monitor pops and compares the predictions.
`default_nettype none

module tb_midi_poly_synth;

    localparam int NV = 4;
    localparam int OW = 16;
    localparam int AS = 6;
    localparam int SD = 3;
    localparam int CH = 0;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [7:0]           midi_data = 8'd0;
    logic                 midi_valid = 1'b0;
    logic signed [OW-1:0] sound_data;
    logic                 sound_valid;
    logic [NV-1:0]        voice_active;

    always #5 clk = ~clk;

    midi_poly_synth #(
        .NUM_VOICES (NV),
        .OUT_W      (OW),
        .AMP_SHIFT  (AS),
        .SAMPLE_DIV (SD),
        .MIDI_CH    (CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .midi_data    (midi_data),
        .midi_valid   (midi_valid),
        .sound_data   (sound_data),
        .sound_valid  (sound_valid),
        .voice_active (voice_active)
    );

    typedef struct {
        int tag;
        int val;
    } exp_t;

    exp_t samp_q[$];
    exp_t act_q[$];
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    int   mon_t = 0;
    int   last_exp = 0;
    bit   mon_en = 1'b0;

    // reference model state: per-voice start time replaces any counter
    int v_act[NV], v_note[NV], v_vel[NV], v_t0[NV];
    int steal, rs, cur, have_note, note_b, skip_left;

    task automatic chk(string name, logic signed [63:0] got, logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, mon_t);
        end
    endtask

    function automatic int hp_ref(int n);
        real x;
        int  r;
        x = 1000.0 * (2.0 ** ((48.0 - real'(n)) / 12.0));
        r = $rtoi(x + 0.5);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int mix_at(int s);
        int sum = 0;
        for (int v = 0; v < NV; v++) begin
            if (v_act[v] != 0) begin
                int amp = v_vel[v] << AS;
                sum += ((((s - v_t0[v]) / hp_ref(v_note[v])) % 2) == 1) ? -amp : amp;
            end
        end
        return sum;
    endfunction

    function automatic int act_mask();
        int m = 0;
        for (int v = 0; v < NV; v++) if (v_act[v] != 0) m |= (1 << v);
        return m;
    endfunction

    function automatic bit ch_ok(int b);
`ifdef MIDI_POLY_SYNTH_CHANNEL_FILTER_EN
        return (b & 15) == CH;
`else
        return (b >= 0);
`endif
    endfunction

    task automatic note_on(int n, int vel, int tt);
        int sel = -1;
        for (int v = 0; v < NV && sel < 0; v++) if (v_act[v] != 0 && v_note[v] == n) sel = v;
        for (int v = 0; v < NV && sel < 0; v++) if (v_act[v] == 0) sel = v;
        if (sel < 0) begin
            sel   = steal;
            steal = (steal + 1) % NV;
        end
        v_act[sel] = 1; v_note[sel] = n; v_vel[sel] = vel; v_t0[sel] = tt;
    endtask

    task automatic note_off(int n);
        for (int v = 0; v < NV; v++) begin
            if (v_act[v] != 0 && v_note[v] == n) begin
                v_act[v] = 0;
                return;
            end
        end
    endtask

    task automatic model_byte(int b, int tt);
        int hi = b >> 4;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            rs = -1; cur = -1; have_note = 0; skip_left = 0;
            return;
        end
        if (b >= 'h80) begin
            have_note = 0;
            if ((hi == 8 || hi == 9) && ch_ok(b)) begin
                rs = hi; cur = hi; skip_left = 0;
            end else begin
                rs = -1; cur = -1;
                skip_left = (hi == 'hC || hi == 'hD) ? 1 : 2;
            end
            return;
        end
        if (skip_left > 0) begin
            skip_left--;
            return;
        end
        if (cur < 0) begin
            if (rs < 0) return;
            cur = rs; note_b = b; have_note = 1;
            return;
        end
        if (have_note == 0) begin
            note_b = b; have_note = 1;
            return;
        end
        if (cur == 9 && b != 0) note_on(note_b, b, tt);
        else note_off(note_b);
        cur = -1; have_note = 0;
    endtask

    // Drive one cycle's input at a negedge, predict its effect, wait a cycle.
    task automatic step(bit v, int b);
        midi_valid = v;
        midi_data  = 8'(b);
        t++;
        if (v) model_byte(b, t);
        act_q.push_back('{t, act_mask()});
        if ((t + 2) % SD == 0) samp_q.push_back('{t + 2, mix_at(t)});
        @(negedge clk);
    endtask

    task automatic send(int b);
        step(1'b1, b);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        midi_valid = 1'b0;
        #1;
        chk("reset_sound_data", sound_data, 0);
        chk("reset_sound_valid", {63'd0, sound_valid}, 0);
        chk("reset_voice_active", {60'd0, voice_active}, 0);
        samp_q.delete();
        act_q.delete();
        for (int v = 0; v < NV; v++) begin
            v_act[v] = 0; v_note[v] = 0; v_vel[v] = 0; v_t0[v] = 0;
        end
        steal = 0; rs = -1; cur = -1; have_note = 0; note_b = 0; skip_left = 0;
        repeat (2) @(negedge clk);
        t        = 0;
        mon_t    = 0;
        last_exp = 0;
        for (int k = 1; k <= 2; k++) if (k % SD == 0) samp_q.push_back('{k, 0});
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && mon_en) begin
            exp_t e;
            bit   exp_v;
            mon_t++;
            if (act_q.size() == 0 || act_q[0].tag != mon_t) begin
                chk("act_sync", (act_q.size() == 0) ? -1 : act_q[0].tag, mon_t);
            end else begin
                e = act_q.pop_front();
                chk("voice_active", {60'd0, voice_active}, e.val);
            end
            exp_v = (samp_q.size() > 0 && samp_q[0].tag == mon_t);
            chk("sound_valid", {63'd0, sound_valid}, {63'd0, exp_v});
            if (exp_v) begin
                e = samp_q.pop_front();
                last_exp = e.val;
            end
            chk("sound_data", sound_data, last_exp);
        end
    end

    function automatic int rand_data();
        int r = $urandom_range(0, 99);
        if (r < 10) return 0;
        if (r < 20) return $urandom_range(0, 127);
        return 60 + $urandom_range(0, 19);
    endfunction

    initial begin
        @(negedge clk);
        do_reset();

        // single note 48 at velocity 64: +/-4096 with half period 1000
        send('h90); send('h30); send('h40);
        idle(2600);

        // running status: notes 60 and 64, both full velocity
        send('h90); send('h3C); send('h7F); send('h40); send('h7F);
        idle(1200);
        send('h80); send('h3C); send('h00); send('h40); send('h00);
        idle(20);

        // Note Off by 0x8n and by velocity-zero Note On
        send('h90); send('h3C); send('h40); idle(30);
        send('h80); send('h3C); send('h00); idle(10);
        send('h90); send('h3C); send('h40); idle(30);
        send('h90); send('h3C); send('h00); idle(10);

        // five then six Note Ons on four voices exercise stealing
        send('h90);
        for (int n = 40; n <= 45; n++) begin
            send(n); send('h20 + n);
            idle(15);
        end
        send('h41); send('h00); idle(10);
        send('h40); send('h00); idle(10);

        // realtime byte inside a message, then a Program Change skip
        send('h90); send('hF8); send('h3C); send('h40); idle(10);
        send('hC0); send('h05); send('h3C); send('h40); idle(10);

        // reset mid-note, then a lone data byte must be ignored
        do_reset();
        send('h3C); send('h40); idle(20);

        for (int n = 0; n < 22000; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 20)      step(1'b0, 0);
            else if (r < 58) send(rand_data());
            else if (r < 76) send(($urandom_range(0, 3) == 0 ? 'h80 : 'h90) | $urandom_range(0, 15));
            else if (r < 81) send('hA0 + ($urandom_range(0, 4) << 4) + $urandom_range(0, 15));
            else if (r < 84) send('hF0 + $urandom_range(0, 7));
            else if (r < 89) send('hF8 + $urandom_range(0, 7));
            else             send(rand_data());
            if (n == 11000) do_reset();
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule

`default_nettype wire
